// File: rtl/data_mem_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the byte-enabled data memory:
//   - access size encodings carried on the 'size' port
//   - FSM state enumeration used by data_mem_be
// ----------------------------------------------------------------------------
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering for a little-endian 32-bit word memory.
//   size     : access size (byte / half / word / reserved)
//   uns      : 1 = zero-extend loads, 0 = sign-extend loads
//   lane     : byte address bits [1:0]
//   wdata    : right-aligned store data
//   rword    : current contents of the addressed word
//   be       : byte enables for a store (all zero when misaligned)
//   wdata_sh : store data replicated into every lane it could land in
//   load_ext : selected lane, extended to 32 bits
//   misalign : access is misaligned or uses the reserved size
// ----------------------------------------------------------------------------
module mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] load_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword[7:0];
        case (lane)
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
        half_sel = lane[1] ? rword[31:16] : rword[15:0];
    end

    // Store data is replicated rather than shifted; the byte enables pick
    // which copy actually lands in memory.
    always_comb begin
        be       = 4'b0000;
        wdata_sh = wdata;
        load_ext = 32'd0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{wdata[7:0]}};
                load_ext = uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misalign = lane[0];
                if (!lane[0]) begin
                    be = lane[1] ? 4'b1100 : 4'b0011;
                end
                wdata_sh = {2{wdata[15:0]}};
                load_ext = uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SZ_WORD: begin
                misalign = (lane != 2'd0);
                if (lane == 2'd0) begin
                    be = 4'b1111;
                end
                load_ext = rword;
            end
            SZ_RSVD: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// ----------------------------------------------------------------------------
// data_mem_be
// Word-organised data memory with byte/half/word access, sign/zero-extended
// loads, optional wait states and a serialised request/response interface.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   req        : access request
//   we         : 1 = store, 0 = load
//   size       : 00 byte, 01 half, 10 word, 11 reserved
//   uns        : 1 = zero-extend loads, 0 = sign-extend
//   addr       : byte address (wraps modulo 4*DEPTH)
//   wdata      : right-aligned store data
//   ready      : request can be accepted this cycle
//   resp_valid : one-cycle completion pulse
//   rdata      : extended load result (0 for stores and errors)
//   err        : completed access was misaligned or reserved
//
// Handshake: a request is taken on a rising edge where req=1 and ready=1;
// the request fields are sampled only on that edge. ready is low while an
// access is in flight. Completion is the single cycle with resp_valid=1,
// WAIT_STATES+2 cycles after the accepting cycle; rdata/err stay valid
// from that cycle until the next completion. There is no back-pressure on
// the response side.
// ----------------------------------------------------------------------------
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_WIDTH  = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] INIT0       = 32'd2,
    parameter logic [31:0] INIT1       = 32'd3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  uns,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;

    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        lane_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;

    logic [31:0]       mem [DEPTH];

    logic [3:0]        be;
    logic [31:0]       wdata_sh;
    logic [31:0]       load_ext;
    logic              misalign;

    // Address bits above the word index are ignored so the space aliases.
    if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[ADDR_WIDTH-1:IDX_W+2];
    end

    mem_lane_align u_align (
        .size     (size_q),
        .uns      (uns_q),
        .lane     (lane_q),
        .wdata    (wdata_q),
        .rword    (mem[idx_q]),
        .be       (be),
        .wdata_sh (wdata_sh),
        .load_ext (load_ext),
        .misalign (misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ready      <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            lane_q     <= 2'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i == 0) ? INIT0 : ((i == 1) ? INIT1 : 32'd0);
            end
        end else begin
            case (state)
                IDLE, RESP: begin
                    resp_valid <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        lane_q  <= addr[1:0];
                        idx_q   <= addr[IDX_W+1:2];
                        wdata_q <= wdata;
                        cnt     <= 4'(WAIT_STATES);
                        ready   <= 1'b0;
                        state   <= BUSY;
                    end else begin
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // The access itself happens on the edge that leaves BUSY.
                        if (misalign) begin
                            rdata <= 32'd0;
                            err   <= 1'b1;
                        end else if (we_q) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[b]) begin
                                    mem[idx_q][8*b +: 8] <= wdata_sh[8*b +: 8];
                                end
                            end
                            rdata <= 32'd0;
                            err   <= 1'b0;
                        end else begin
                            rdata <= load_ext;
                            err   <= 1'b0;
                        end
                        resp_valid <= 1'b1;
                        ready      <= 1'b1;
                        state      <= RESP;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    ready      <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_be.sv
// ----------------------------------------------------------------------------
// tb_data_mem_be
// Two instances: inst0 with default parameters, inst1 with WAIT_STATES=3.
// The reference model keeps memory as a flat byte array per instance and a
// queue of expected responses tagged with the cycle they must appear in.
// ----------------------------------------------------------------------------
module tb_data_mem_be;
    import data_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic        req_s   [2];
    logic        we_s    [2];
    logic [1:0]  size_s  [2];
    logic        uns_s   [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic        ready_s [2];
    logic        rv_s    [2];
    logic [31:0] rdata_s [2];
    logic        err_s   [2];

    data_mem_be #(.DEPTH(64), .ADDR_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
        .uns(uns_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]),
        .resp_valid(rv_s[0]), .rdata(rdata_s[0]), .err(err_s[0])
    );

    data_mem_be #(.DEPTH(64), .ADDR_WIDTH(32), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
        .uns(uns_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]),
        .resp_valid(rv_s[1]), .rdata(rdata_s[1]), .err(err_s[1])
    );

    // ---------------- model ----------------
    typedef struct {
        int          id;
        int          cyc;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mb [2][256];
    int          acc [2];
    logic [31:0] held_rd [2];
    logic        held_er [2];
    logic        chk_en = 1'b0;

    int tests_run = 0;
    int fails     = 0;

    function automatic int wait_of(input int id);
        return (id == 1) ? 3 : 0;
    endfunction

    function automatic void model_reset();
        for (int id = 0; id < 2; id++) begin
            for (int i = 0; i < 256; i++) mb[id][i] = 8'h00;
            mb[id][0] = 8'd2;
            mb[id][4] = 8'd3;
            acc[id]     = -100;
            held_rd[id] = 32'd0;
            held_er[id] = 1'b0;
        end
        exp_q.delete();
    endfunction

    // Byte-array view of the access rules: n bytes at byte address ba.
    function automatic void model_access(input int id, input logic w, input logic [1:0] sz,
                                         input logic u, input logic [31:0] ad,
                                         input logic [31:0] wd,
                                         output logic [31:0] rd, output logic er);
        int n;
        int ba;
        logic [31:0] v;
        n  = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        ba = int'(ad % 32'd256);
        er = (sz == 2'b11) || ((ba % n) != 0);
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[id][ba+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mb[id][ba+i];
                if (!u && n < 4 && v[8*n-1]) begin
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
                end
                rd = v;
            end
        end
    endfunction

    task automatic chk(input string nm, input int id, input logic [31:0] got,
                       input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", nm, id, cyc, got, exp);
        end
    endtask

    // ---------------- compare process ----------------
    logic e_rv;
    logic e_rdy;
    int   cws;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int id = 0; id < 2; id++) begin
                cws   = wait_of(id);
                e_rdy = !((cyc >= acc[id]) && (cyc <= acc[id] + cws));
                e_rv  = (exp_q.size() > 0) && (exp_q[0].id == id) && (exp_q[0].cyc == cyc);
                if (e_rv) begin
                    held_rd[id] = exp_q[0].rd;
                    held_er[id] = exp_q[0].er;
                end
                chk("ready", id, 32'(ready_s[id]), 32'(e_rdy));
                chk("resp_valid", id, 32'(rv_s[id]), 32'(e_rv));
                chk("rdata", id, rdata_s[id], held_rd[id]);
                chk("err", id, 32'(err_s[id]), 32'(held_er[id]));
            end
            if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the edge that
    // starts the response cycle, where the literal expectations are checked.
    task automatic access(input int id, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] ad, input logic [31:0] wd, input logic keep,
                          input logic [31:0] lit_rd, input logic lit_er);
        exp_t e;
        int   ws;
        ws          = wait_of(id);
        req_s[id]   = 1'b1;
        we_s[id]    = w;
        size_s[id]  = sz;
        uns_s[id]   = u;
        addr_s[id]  = ad;
        wdata_s[id] = wd;
        model_access(id, w, sz, u, ad, wd, e.rd, e.er);
        e.id  = id;
        e.cyc = cyc + ws + 2;
        exp_q.push_back(e);
        acc[id] = cyc + 1;
        @(posedge clk); #1;
        if (!keep) req_s[id] = 1'b0;
        repeat (ws + 1) begin
            @(posedge clk); #1;
        end
        chk("lit_rdata", id, rdata_s[id], lit_rd);
        chk("lit_err", id, 32'(err_s[id]), 32'(lit_er));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int id = 0; id < 2; id++) begin
            req_s[id] = 1'b0; we_s[id] = 1'b0; size_s[id] = SZ_WORD; uns_s[id] = 1'b0;
            addr_s[id] = 32'd0; wdata_s[id] = 32'd0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        chk("reset_ready", 0, 32'(ready_s[0]), 32'd1);
        chk("reset_rv", 0, 32'(rv_s[0]), 32'd0);
        chk("reset_rdata", 0, rdata_s[0], 32'd0);

        // Reset contents and 2-cycle latency.
        access(0, 0, SZ_WORD, 0, 32'd0, 32'd0, 0, 32'd2, 0);
        access(0, 0, SZ_WORD, 0, 32'd4, 32'd0, 0, 32'd3, 0);
        // Byte-enable merge.
        access(0, 1, SZ_WORD, 0, 32'd8, 32'h11223344, 0, 32'd0, 0);
        access(0, 1, SZ_BYTE, 0, 32'd9, 32'h123456AA, 0, 32'd0, 0);
        access(0, 0, SZ_WORD, 0, 32'd8, 32'd0, 0, 32'h1122AA44, 0);
        // Extension.
        access(0, 0, SZ_BYTE, 0, 32'd9, 32'd0, 0, 32'hFFFFFFAA, 0);
        access(0, 0, SZ_BYTE, 1, 32'd9, 32'd0, 0, 32'h000000AA, 0);
        access(0, 0, SZ_HALF, 0, 32'd10, 32'd0, 0, 32'h00001122, 0);
        access(0, 0, SZ_HALF, 0, 32'd8, 32'd0, 0, 32'hFFFFAA44, 0);
        access(0, 0, SZ_HALF, 1, 32'd8, 32'd0, 0, 32'h0000AA44, 0);
        access(0, 0, SZ_BYTE, 1, 32'd11, 32'd0, 0, 32'h00000011, 0);
        access(0, 1, SZ_WORD, 1, 32'd8, 32'd0, 0, 32'd0, 0);
        access(0, 0, SZ_WORD, 1, 32'd8, 32'd0, 0, 32'd0, 0);
        // Errors leave memory unchanged.
        access(0, 1, SZ_HALF, 0, 32'd3, 32'h0000BEEF, 0, 32'd0, 1);
        access(0, 0, SZ_WORD, 0, 32'd0, 32'd0, 0, 32'd2, 0);
        access(0, 1, SZ_HALF, 0, 32'd2, 32'h00008001, 0, 32'd0, 0);
        access(0, 0, SZ_HALF, 0, 32'd2, 32'd0, 0, 32'hFFFF8001, 0);
        access(0, 0, SZ_WORD, 0, 32'd0, 32'd0, 0, 32'h80010002, 0);
        access(0, 0, SZ_RSVD, 0, 32'd0, 32'd0, 0, 32'd0, 1);
        access(0, 0, SZ_WORD, 0, 32'd6, 32'd0, 0, 32'd0, 1);
        access(0, 0, SZ_HALF, 1, 32'd7, 32'd0, 0, 32'd0, 1);

        // Reset while a store is in BUSY: aborted, no response.
        req_s[0] = 1'b1; we_s[0] = 1'b1; size_s[0] = SZ_WORD; addr_s[0] = 32'd48;
        wdata_s[0] = 32'h00000055;
        acc[0] = cyc + 1;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        chk("abort_ready", 0, 32'(ready_s[0]), 32'd1);
        chk("abort_rv", 0, 32'(rv_s[0]), 32'd0);
        access(0, 0, SZ_WORD, 0, 32'd48, 32'd0, 0, 32'd0, 0);
        access(0, 0, SZ_WORD, 0, 32'd0, 32'd0, 0, 32'd2, 0);

        // Wait states, back-to-back with req held, and address aliasing.
        access(1, 1, SZ_WORD, 0, 32'd260, 32'hDEADBEEF, 1, 32'd0, 0);
        access(1, 0, SZ_WORD, 0, 32'd4, 32'd0, 1, 32'hDEADBEEF, 0);
        access(1, 0, SZ_BYTE, 1, 32'd263, 32'd0, 1, 32'h000000DE, 0);
        access(1, 0, SZ_HALF, 0, 32'd6, 32'd0, 0, 32'hFFFFDEAD, 0);

        repeat (6) @(posedge clk);
        #1;
        chk("queue_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words (power of two, at least 4).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the byte-address width.
REQ-003 The block SHALL have parameter WAIT_STATES, default 0, giving the extra busy cycles per access (0..15).
REQ-004 The block SHALL have parameters INIT0 and INIT1, defaults 32'd2 and 32'd3, giving the reset contents of words 0 and 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port req, input, 1 bit: access request, sampled only when ready=1.
REQ-008 The block SHALL have port we, input, 1 bit: 1=store, 0=load.
REQ-009 The block SHALL have port size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-010 The block SHALL have port uns, input, 1 bit: 1 zero-extends loads, 0 sign-extends loads.
REQ-011 The block SHALL have port addr, input, ADDR_WIDTH bits: byte address.
REQ-012 The block SHALL have port wdata, input, 32 bits: store data, right-aligned.
REQ-013 The block SHALL have port ready, output, 1 bit: the block can accept a request this cycle.
REQ-014 The block SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-015 The block SHALL have port rdata, output, 32 bits: extended load result.
REQ-016 The block SHALL have port err, output, 1 bit: the completed access was misaligned or reserved; valid with resp_valid.

Function
REQ-017 The block SHALL implement FSM states IDLE, BUSY and RESP; a request is accepted on an edge where req=1 and ready=1.
REQ-018 The block SHALL drive ready=1 in IDLE and RESP, and ready=0 in BUSY.
REQ-019 On acceptance the block SHALL register we, size, uns, addr and wdata, load a counter with WAIT_STATES, and enter BUSY.
REQ-020 In BUSY the block SHALL decrement the counter when it is nonzero; when it is zero it SHALL perform the access on that edge and enter RESP.
REQ-021 The block SHALL assert resp_valid=1 only in RESP, so completion falls exactly WAIT_STATES+2 cycles after the accepting cycle.
REQ-022 From RESP the block SHALL go to BUSY if req=1, else to IDLE, so back-to-back throughput is one access per WAIT_STATES+2 cycles.
REQ-023 The block SHALL compute word index = addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-024 The block SHALL use little-endian byte lanes: byte lane = addr[1:0], half lane = addr[1].
REQ-025 A half access with addr[0]=1, a word access with addr[1:0]!=0, or size=11 SHALL be an error: no memory change, rdata=0, err=1 in RESP.
REQ-026 A store SHALL write only the addressed byte or bytes (byte-enable merge), leave the other bytes unchanged, set rdata=0 and set err=0.
REQ-027 A load SHALL return the selected lane, zero-extended when uns=1 and sign-extended from its top bit when uns=0; uns SHALL be ignored for word loads.
REQ-028 The block SHALL hold rdata and err stable from RESP until the next RESP.
REQ-029 A store followed by a load to the same word SHALL return the new data, since the accesses are strictly serialised.

Reset
REQ-030 When rst=1 at an edge, the block SHALL go to IDLE, clear the counter, set resp_valid=0, rdata=0 and err=0, write all words to 0 except word0=INIT0 and word1=INIT1, and have ready=1 in the following cycle.
REQ-031 A reset during BUSY or RESP SHALL abort the access: no write occurs and no resp_valid is produced.
REQ-032 The rst input SHALL take priority over req on the same edge.

Structure
REQ-033 Package data_mem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state enum.
REQ-034 Sub-module mem_lane_align SHALL be purely combinational: it SHALL produce the 4-bit byte enable, the shifted store data, the extended load data and the misalign flag from size, uns, addr[1:0], wdata and the word read.

Verification
REQ-035 Reset with defaults, then load word at addr 0 and addr 4 -> rdata 2 then 3, err=0, each resp_valid exactly 2 cycles after acceptance.
REQ-036 Store word 0x11223344 at addr 8, then store byte 0xAA at addr 9, then load word at addr 8 -> rdata 0x1122AA44.
REQ-037 With word 8 = 0x1122AA44: load byte signed at addr 9 -> 0xFFFFFFAA; unsigned -> 0x000000AA; load half signed at addr 10 -> 0x00001122.
REQ-038 Store half at addr 3 -> err=1, memory unchanged; load with size=11 -> err=1, rdata=0.
REQ-039 WAIT_STATES=3 with back-to-back req held high -> ready low 4 cycles per access, resp_valid every 5 cycles; addr 4*DEPTH+4 aliases word 1.
REQ-040 Assert rst in BUSY during a store -> target word unchanged, no resp_valid, ready=1 in the cycle after reset.
